// File: rtl/row_window_feeder.sv
// row_window_feeder
//   Producer side of the three-row BorderDetection interface. Accepts a raster-order
//   pixel stream (valid/ready), assembles rows and presents three consecutive complete
//   rows as a window that is held until the consumer acknowledges it.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pix_in          pixel data
//   pix_valid       pix_in valid
//   pix_ready       feeder can accept a pixel
//   sof             start of frame, qualified by pix_valid & pix_ready
//   row_top         oldest row of the window; pixel x at [x*PIX_W +: PIX_W]
//   row_mid         centre row of the window
//   row_bot         newest row of the window
//   win_valid       row_top/mid/bot form a valid window
//   win_ack         consumer took the window (ignored while win_valid=0)
//   centre_y        row index of row_mid
//   frame_done      one-cycle pulse after the last window of a frame is acked
module row_window_feeder #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned PIX_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_W-1:0]          pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic                      sof,
    output logic [WIDTH*PIX_W-1:0]    row_top,
    output logic [WIDTH*PIX_W-1:0]    row_mid,
    output logic [WIDTH*PIX_W-1:0]    row_bot,
    output logic                      win_valid,
    input  logic                      win_ack,
    output logic [$clog2(HEIGHT)-1:0] centre_y,
    output logic                      frame_done
);

    localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RowW = $clog2(HEIGHT);
    localparam int unsigned BusW = WIDTH * PIX_W;

    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    logic [BusW-1:0]   fill_q, fill_d;
    logic [BusW-1:0]   top_q, top_d;
    logic [BusW-1:0]   mid_q, mid_d;
    logic [BusW-1:0]   bot_q, bot_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [1:0]        loaded_q, loaded_d;
    logic              win_valid_q, win_valid_d;
    logic [RowW-1:0]   centre_q, centre_d;
    logic              frame_done_q, frame_done_d;

    logic              xfer;
    logic              ack;
    logic              rotate;
    logic [BusW-1:0]   fill_merged;

    assign pix_ready  = (state_q == StRun);
    assign xfer       = pix_valid & pix_ready;
    assign ack        = win_valid_q & win_ack;

    assign row_top    = top_q;
    assign row_mid    = mid_q;
    assign row_bot    = bot_q;
    assign win_valid  = win_valid_q;
    assign centre_y   = centre_q;
    assign frame_done = frame_done_q;

    always_comb begin
        fill_merged = fill_q;
        fill_merged[col_q*PIX_W +: PIX_W] = pix_in;
    end

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        col_d        = col_q;
        row_d        = row_q;
        loaded_d     = loaded_q;
        win_valid_d  = win_valid_q;
        centre_d     = centre_q;
        frame_done_d = 1'b0;
        rotate       = 1'b0;

        // An ack retires the window; a rotation on the same edge re-raises it below.
        if (ack) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (xfer) begin
                    if (sof) begin
                        // Abort the frame; the sof pixel becomes pixel (0,0) of row 0.
                        fill_d                 = fill_q;
                        fill_d[0 +: PIX_W]     = pix_in;
                        col_d                  = ColW'(1);
                        row_d                  = '0;
                        loaded_d               = 2'd0;
                        win_valid_d            = 1'b0;
                    end else if (col_q == ColLast) begin
                        fill_d = fill_merged;
                        if (win_valid_q && !win_ack) begin
                            // Rows must stay stable for the pending window.
                            state_d = StStall;
                        end else begin
                            rotate = 1'b1;
                        end
                    end else begin
                        fill_d = fill_merged;
                        col_d  = col_q + ColW'(1);
                    end
                end
            end
            StStall: begin
                if (ack) begin
                    rotate = 1'b1;
                end
            end
            StFlush: begin
                if (ack) begin
                    frame_done_d = 1'b1;
                    row_d        = '0;
                    loaded_d     = 2'd0;
                    col_d        = '0;
                    state_d      = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (rotate) begin
            // fill_d holds the completed row in both RUN and STALL.
            top_d       = mid_q;
            mid_d       = bot_q;
            bot_d       = fill_d;
            col_d       = '0;
            row_d       = row_q + RowW'(1);
            loaded_d    = (loaded_q == 2'd3) ? 2'd3 : loaded_q + 2'd1;
            win_valid_d = (loaded_q >= 2'd2);
            centre_d    = row_q - RowW'(1);
            state_d     = (row_q == RowLast) ? StFlush : StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            fill_q       <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            loaded_q     <= 2'd0;
            win_valid_q  <= 1'b0;
            centre_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            col_q        <= col_d;
            row_q        <= row_d;
            loaded_q     <= loaded_d;
            win_valid_q  <= win_valid_d;
            centre_q     <= centre_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
